// File: rtl/program_loader.sv
// program_loader: assembles a little-endian byte stream into 32-bit words, writes them to instruction memory, then releases the CPU.
module program_loader #(
  parameter int addr_width = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rstn,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded,
  input  logic        reload
);
  localparam logic [2:0] LEN0 = 3'd0, LEN1 = 3'd1, DATA = 3'd2, WRITE = 3'd3, DONE = 3'd4, ERROR = 3'd5;
  localparam logic [16:0] cap = 17'(1) << addr_width;
  logic [2:0]  state;
  logic [15:0] n, word_index, len;
  logic [1:0]  byte_index;
  logic [23:0] sh;
  logic        take;
  assign in_ready = !rst && (state == LEN0 || state == LEN1 || state == DATA);
  assign imem_we  = state == WRITE;
  assign done     = state == DONE;
  assign cpu_rstn = state == DONE;
  assign error    = state == ERROR;
  assign take     = in_valid && in_ready;
  assign len      = {in_data, n[7:0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LEN0;
      n            <= '0;
      word_index   <= '0;
      byte_index   <= '0;
      sh           <= '0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        LEN0: if (take) begin
          n[7:0] <= in_data;
          state  <= LEN1;
        end
        LEN1: if (take) begin
          n[15:8]    <= in_data;
          word_index <= '0;
          byte_index <= '0;
          state      <= len == 16'd0 ? DONE : {1'b0, len} > cap ? ERROR : DATA;
        end
        DATA: if (take) begin
          sh         <= {in_data, sh[23:8]};
          byte_index <= byte_index + 2'd1;
          if (byte_index == 2'd3) begin
            imem_wdata <= {in_data, sh};
            imem_addr  <= {46'd0, word_index, 2'b00};
            state      <= WRITE;
          end
        end
        WRITE: begin
          word_index   <= word_index + 16'd1;
          words_loaded <= words_loaded == 16'hffff ? words_loaded : words_loaded + 16'd1;
          byte_index   <= '0;
          state        <= word_index + 16'd1 == n ? DONE : DATA;
        end
        DONE, ERROR: if (reload) begin
          state        <= LEN0;
          words_loaded <= '0;
        end
        default: state <= LEN0;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed-vector bench for program_loader with a write monitor.
module tb_program_loader;
  logic        clk = 0, rst = 1, in_valid = 0, reload = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, imem_we, cpu_rstn, done, error;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] words_loaded;
  int checks = 0, failures = 0, overlap = 0;
  logic [63:0] wa[$];
  logic [31:0] wd[$];
  logic throttle = 0;

  program_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rstn(cpu_rstn),
    .done(done), .error(error), .words_loaded(words_loaded), .reload(reload)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
    if (imem_we && in_ready) overlap++;
  end

  task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task send(input logic [7:0] b);
    int k;
    if (throttle) begin
      in_valid = 0;
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    in_data = b;
    in_valid = 1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("send_timeout", 0, 1);
    @(negedge clk);
  endtask

  task pulse_reload;
    reload = 1;
    @(negedge clk);
    reload = 0;
  endtask

  task send_two_word;
    logic [7:0] s [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    foreach (s[i]) send(s[i]);
    in_valid = 0;
  endtask

  initial begin
    int base, k;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_outs", {cpu_rstn, done, error, words_loaded, imem_addr, imem_wdata}, 0);
    rst = 0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    send(8'h02); send(8'h00); send(8'h13); send(8'h05); send(8'h10); send(8'h00);
    check("w0_we", imem_we, 1);
    check("w0_in_ready", in_ready, 0);
    check("w0_addr", imem_addr, 64'h0);
    check("w0_data", imem_wdata, 32'h00100513);
    send(8'h93); send(8'h05); send(8'h20); send(8'h00);
    in_valid = 0;
    check("w1_we", imem_we, 1);
    check("w1_addr", imem_addr, 64'h4);
    check("w1_data", imem_wdata, 32'h00200593);
    check("w1_wl_before", words_loaded, 1);
    @(negedge clk);
    check("two_done", {done, cpu_rstn, in_ready, imem_we}, 4'b1100);
    check("two_wl", words_loaded, 2);
    check("two_nwrites", wa.size(), 2);
    check("two_hold_data", imem_wdata, 32'h00200593);

    pulse_reload();
    check("empty_reload", {cpu_rstn, done, error, in_ready}, 4'b0001);
    check("empty_reload_wl", words_loaded, 0);
    send(8'h00); send(8'h00);
    in_valid = 0;
    check("empty_done", {done, cpu_rstn}, 2'b11);
    check("empty_nwrites", wa.size(), 2);

    pulse_reload();
    send(8'h01); send(8'h01);
    in_valid = 0;
    check("over_err", {error, cpu_rstn, in_ready, done}, 4'b1000);
    @(negedge clk);
    check("over_sticky", error, 1);
    pulse_reload();
    check("over_clear", {error, in_ready}, 2'b01);

    base = wa.size();
    throttle = 1;
    send_two_word();
    throttle = 0;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("thr_done", done, 1);
    check("thr_nwrites", wa.size() - base, 2);
    check("thr_addr0", wa[base], 64'h0);
    check("thr_data0", wd[base], 32'h00100513);
    check("thr_addr1", wa[base+1], 64'h4);
    check("thr_data1", wd[base+1], 32'h00200593);
    check("thr_wl", words_loaded, 2);

    pulse_reload();
    base = wa.size();
    send(8'h02); send(8'h00); send(8'h13); send(8'h05); send(8'h10);
    rst = 1;
    #1;
    check("mid_rst_outs", {in_ready, imem_we, cpu_rstn, done, error, words_loaded, imem_addr, imem_wdata}, 0);
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    repeat (3) @(negedge clk);
    check("mid_rst_nowrite", wa.size() - base, 0);
    check("mid_rst_ready", in_ready, 1);
    send(8'h01); send(8'h00); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    in_valid = 0;
    check("fresh_we", imem_we, 1);
    check("fresh_addr", imem_addr, 64'h0);
    check("fresh_data", imem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("fresh_done", {done, cpu_rstn}, 2'b11);

    pulse_reload();
    check("rel_cpu_rstn", {cpu_rstn, done, words_loaded}, 0);
    base = wa.size();
    send(8'h01); send(8'h00); send(8'h73); send(8'h00); send(8'h10); send(8'h00);
    in_valid = 0;
    @(negedge clk);
    check("rel_nwrites", wa.size() - base, 1);
    check("rel_addr", wa[base], 64'h0);
    check("rel_data", wd[base], 32'h00100073);
    check("rel_wl", words_loaded, 1);
    check("rel_done", {done, cpu_rstn}, 2'b11);
    check("no_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
